// File: rtl/pio_led_pkg.sv
// Shared constants for the pio_led_ctrl LED output port: register word
// addresses and STATUS register bit positions.
package pio_led_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_SET          = 3'd1;
  localparam logic [2:0] ADDR_CLEAR        = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN     = 3'd4;
  localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_PWM_DUTY     = 3'd6;
  localparam logic [2:0] ADDR_STATUS       = 3'd7;

  localparam int unsigned STATUS_PHASE_BIT = 0;
  localparam int unsigned STATUS_PWM_LSB   = 16;

endpackage

// File: rtl/pio_led_prescaler.sv
// Blink prescaler: counts 0..period-1 and inverts phase on each wrap, so one
// blink half-period lasts exactly `period` clock cycles.
module pio_led_prescaler #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             reload,
  output logic             phase
);

  logic [CNT_W-1:0] cnt_q;

  // Reload has priority over the terminal count so a period write always
  // restarts cleanly at counter 0, phase 1.
  always_ff @(posedge clk) begin
    if (reset || reload || period == '0) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (cnt_q == period - 1'b1) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pio_led_ctrl.sv
// Avalon-MM LED output port: DATA register with atomic set/clear/toggle,
// per-channel blink gating and a global PWM brightness stage.
module pio_led_ctrl
  import pio_led_pkg::*;
#(
  parameter int unsigned      WIDTH               = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE         = '0,
  parameter int unsigned      CNT_W               = 26,
  parameter int unsigned      DEFAULT_HALF_PERIOD = 25_000_000,
  parameter int unsigned      PWM_W               = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(DEFAULT_HALF_PERIOD);
  localparam logic [PWM_W-1:0] PWM_LAST   = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] blink_en_q;
  logic [CNT_W-1:0] period_q;
  logic [PWM_W-1:0] duty_q;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             wr_en;
  logic             period_wr;
  logic             phase;
  logic             pwm_on;
  logic [WIDTH-1:0] wd_ch;
  logic             unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);
  assign wd_ch     = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
      period_q   <= PERIOD_RST;
      duty_q     <= '1;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:         data_q     <= wd_ch;
        ADDR_SET:          data_q     <= data_q | wd_ch;
        ADDR_CLEAR:        data_q     <= data_q & ~wd_ch;
        ADDR_TOGGLE:       data_q     <= data_q ^ wd_ch;
        ADDR_BLINK_EN:     blink_en_q <= wd_ch;
        ADDR_BLINK_PERIOD: period_q   <= writedata[CNT_W-1:0];
        ADDR_PWM_DUTY:     duty_q     <= writedata[PWM_W-1:0];
        default: ;
      endcase
    end
  end

  pio_led_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .period (period_q),
    .reload (period_wr),
    .phase  (phase)
  );

  // Counter skips the all-ones value so duty=all-ones is permanently on.
  always_ff @(posedge clk) begin
    if (reset || pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= '0;
    end else begin
      out_port <= data_q & (~blink_en_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata[WIDTH-1:0] = data_q;
      ADDR_BLINK_EN:     readdata[WIDTH-1:0] = blink_en_q;
      ADDR_BLINK_PERIOD: readdata[CNT_W-1:0] = period_q;
      ADDR_PWM_DUTY:     readdata[PWM_W-1:0] = duty_q;
      ADDR_STATUS: begin
        readdata[STATUS_PHASE_BIT]         = phase;
        readdata[STATUS_PWM_LSB +: PWM_W]  = pwm_cnt_q;
      end
      default: ;
    endcase
  end

endmodule
